// File: rtl/can_register_bank.sv
// Parameterised CAN controller register bank: per-register access modes
// (RW/RO/W1C/RC), write-protect lock, shadow registers with commit, and
// per-bit hardware set requests that always win over software clears.
module can_register_bank #(
    parameter int                       WIDTH       = 8,
    parameter int                       DEPTH       = 4,
    parameter int                       ADDR_W      = 2,
    parameter logic [DEPTH*WIDTH-1:0]   RESET_VALUE = '0,
    parameter logic [2*DEPTH-1:0]       MODE        = '0,
    parameter logic [DEPTH-1:0]         LOCK_MASK   = '0,
    parameter logic [DEPTH-1:0]         SHADOW_MASK = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rst_sync,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     we,
    input  logic                     re,
    input  logic                     lock,
    input  logic                     commit,
    input  logic [DEPTH*WIDTH-1:0]   hw_set,
    output logic [WIDTH-1:0]         data_out,
    output logic [DEPTH*WIDTH-1:0]   data_q,
    output logic [DEPTH-1:0]         pending,
    output logic                     wr_err
);

    localparam logic [1:0] MODE_RW  = 2'd0;
    localparam logic [1:0] MODE_RO  = 2'd1;
    localparam logic [1:0] MODE_W1C = 2'd2;
    localparam logic [1:0] MODE_RC  = 2'd3;

    // Configuration sanity checks, evaluated at elaboration.
    if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
        $error("can_register_bank: DEPTH must be in 2..16");
    end
    if ((2 ** ADDR_W) < DEPTH) begin : g_bad_addr_w
        $error("can_register_bank: ADDR_W too small for DEPTH");
    end
    for (genvar g = 0; g < DEPTH; g++) begin : g_cfg_check
        // W1C and RC both have MODE bit 1 set; neither can be shadowed.
        if (SHADOW_MASK[g] && MODE[2*g+1]) begin : g_bad_shadow
            $error("can_register_bank: shadowed register must be RW or RO");
        end
    end

    logic [WIDTH-1:0] live_q   [DEPTH];
    logic [WIDTH-1:0] live_d   [DEPTH];
    logic [WIDTH-1:0] shadow_q [DEPTH];
    logic [WIDTH-1:0] shadow_d [DEPTH];
    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;

    logic             addr_ok;
    logic [1:0]       sel_mode;
    logic             sel_lock;
    logic [WIDTH-1:0] rd_data;
    logic             wr_ok;
    logic             wr_rej;
    logic [DEPTH-1:0] wr_hit;
    logic [DEPTH-1:0] rd_hit;

    // Decode the addressed register: its mode, lock bit and current value.
    always_comb begin
        addr_ok  = (int'(addr) < DEPTH);
        sel_mode = MODE_RW;
        sel_lock = 1'b0;
        rd_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(addr) == i) begin
                sel_mode = MODE[2*i +: 2];
                sel_lock = LOCK_MASK[i];
                rd_data  = live_q[i];
            end
        end
        wr_ok  = we && addr_ok && (sel_mode != MODE_RO) && !(lock && sel_lock);
        wr_rej = we && !wr_ok;
    end

    // One-hot write and read strobes per register.
    always_comb begin
        wr_hit = '0;
        rd_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_hit[i] = wr_ok && (int'(addr) == i);
            rd_hit[i] = re && (int'(addr) == i);
        end
    end

    // Next-state per register; hw_set is ORed last so it wins over any clear.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            live_d[i]    = live_q[i];
            shadow_d[i]  = shadow_q[i];
            pending_d[i] = pending_q[i];
            if (SHADOW_MASK[i]) begin
                if (wr_hit[i]) begin
                    shadow_d[i] = data_in;
                end
                if (commit) begin
                    // A write in the commit cycle goes straight through.
                    live_d[i]    = wr_hit[i] ? data_in : shadow_q[i];
                    pending_d[i] = 1'b0;
                end else if (wr_hit[i]) begin
                    pending_d[i] = 1'b1;
                end
            end else if (wr_hit[i]) begin
                if (MODE[2*i +: 2] == MODE_W1C) begin
                    live_d[i] = live_q[i] & ~data_in;
                end else begin
                    live_d[i] = data_in;
                end
            end else if (rd_hit[i] && (MODE[2*i +: 2] == MODE_RC)) begin
                // A same-cycle write takes precedence over clear-on-read.
                live_d[i] = '0;
            end
            live_d[i] = live_d[i] | hw_set[i*WIDTH +: WIDTH];
        end
    end

    // State registers; the synchronous reset also swallows same-cycle accesses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                live_q[i]   <= RESET_VALUE[i*WIDTH +: WIDTH];
                shadow_q[i] <= RESET_VALUE[i*WIDTH +: WIDTH];
            end
            pending_q <= '0;
            data_out  <= '0;
            wr_err    <= 1'b0;
        end else if (rst_sync) begin
            for (int i = 0; i < DEPTH; i++) begin
                live_q[i]   <= RESET_VALUE[i*WIDTH +: WIDTH];
                shadow_q[i] <= RESET_VALUE[i*WIDTH +: WIDTH];
            end
            pending_q <= '0;
            data_out  <= '0;
            wr_err    <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                live_q[i]   <= live_d[i];
                shadow_q[i] <= shadow_d[i];
            end
            pending_q <= pending_d;
            if (re) begin
                // rd_data is already zero for out-of-range addresses.
                data_out <= rd_data;
            end
            wr_err <= wr_rej;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_data_q
        assign data_q[g*WIDTH +: WIDTH] = live_q[g];
    end

    assign pending = pending_q;

endmodule

// File: tb/tb_can_register_bank.sv
// Directed bench for can_register_bank. Two instances share all inputs:
// dut_a has reg3 as a shadowed RW register, dut_b has reg3 read-only.
module tb_can_register_bank;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AW = 3;
    localparam logic [D*W-1:0] RV      = 32'h075A_0011;
    // reg3 RW, reg2 RC, reg1 W1C, reg0 RW
    localparam logic [2*D-1:0] MODE_A  = 8'b00_11_10_00;
    // reg3 RO, reg2 RC, reg1 W1C, reg0 RW
    localparam logic [2*D-1:0] MODE_B  = 8'b01_11_10_00;

    logic           clk = 1'b0;
    logic           rst;
    logic           rst_sync;
    logic [AW-1:0]  addr;
    logic [W-1:0]   data_in;
    logic           we;
    logic           re;
    logic           lock;
    logic           commit;
    logic [D*W-1:0] hw_set;

    logic [W-1:0]   data_out_a, data_out_b;
    logic [D*W-1:0] data_q_a, data_q_b;
    logic [D-1:0]   pending_a, pending_b;
    logic           wr_err_a, wr_err_b;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    can_register_bank #(
        .WIDTH(W), .DEPTH(D), .ADDR_W(AW), .RESET_VALUE(RV),
        .MODE(MODE_A), .LOCK_MASK(4'b0001), .SHADOW_MASK(4'b1000)
    ) dut_a (
        .clk(clk), .rst(rst), .rst_sync(rst_sync), .addr(addr),
        .data_in(data_in), .we(we), .re(re), .lock(lock), .commit(commit),
        .hw_set(hw_set), .data_out(data_out_a), .data_q(data_q_a),
        .pending(pending_a), .wr_err(wr_err_a)
    );

    can_register_bank #(
        .WIDTH(W), .DEPTH(D), .ADDR_W(AW), .RESET_VALUE(RV),
        .MODE(MODE_B), .LOCK_MASK(4'b0001), .SHADOW_MASK(4'b0000)
    ) dut_b (
        .clk(clk), .rst(rst), .rst_sync(rst_sync), .addr(addr),
        .data_in(data_in), .we(we), .re(re), .lock(lock), .commit(commit),
        .hw_set(hw_set), .data_out(data_out_b), .data_q(data_q_b),
        .pending(pending_b), .wr_err(wr_err_b)
    );

    // Clock
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we      = 1'b0;
        re      = 1'b0;
        commit  = 1'b0;
        hw_set  = '0;
        rst_sync = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s: no expected value queued, observed=%0h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s: observed=%0h expected=%0h", tag, obs, e);
            end
        end
    endtask

    function automatic logic [31:0] reg_of(input logic [D*W-1:0] q, input int i);
        return 32'(q[i*W +: W]);
    endfunction

    initial begin
        rst = 1'b1; rst_sync = 1'b0; addr = '0; data_in = '0;
        we = 1'b0; re = 1'b0; lock = 1'b0; commit = 1'b0; hw_set = '0;

        // Reset state
        push_exp(RV); push_exp(0); push_exp(0); push_exp(0);
        cyc(); cyc();
        check("reset_data_q", data_q_a);
        check("reset_pending", 32'(pending_a));
        check("reset_data_out", 32'(data_out_a));
        check("reset_wr_err", 32'(wr_err_a));
        rst = 1'b0;

        // W1C with hardware set
        hw_set = 32'h0000_8100; push_exp(8'h81);
        cyc(); idle();
        check("w1c_hwset", reg_of(data_q_a, 1));
        we = 1'b1; addr = 3'd1; data_in = 8'h01; push_exp(8'h80);
        cyc(); idle();
        check("w1c_clear_bit0", reg_of(data_q_a, 1));
        we = 1'b1; addr = 3'd1; data_in = 8'h80; hw_set = 32'h0000_8000;
        push_exp(8'h80); push_exp(0);
        cyc(); idle();
        check("w1c_set_wins", reg_of(data_q_a, 1));
        check("w1c_no_wr_err", 32'(wr_err_a));

        // Clear-on-read
        re = 1'b1; addr = 3'd2; push_exp(8'h5A); push_exp(8'h00);
        cyc(); idle();
        check("rc_read_data", 32'(data_out_a));
        check("rc_cleared", reg_of(data_q_a, 2));
        we = 1'b1; addr = 3'd2; data_in = 8'h5A; push_exp(8'h5A);
        cyc(); idle();
        check("rc_write", reg_of(data_q_a, 2));
        re = 1'b1; addr = 3'd2; hw_set = 32'h0001_0000; push_exp(8'h5A); push_exp(8'h01);
        cyc(); idle();
        check("rc_read_data2", 32'(data_out_a));
        check("rc_set_wins", reg_of(data_q_a, 2));
        push_exp(8'h5A);
        cyc();
        check("data_out_hold", 32'(data_out_a));
        we = 1'b1; re = 1'b1; addr = 3'd2; data_in = 8'h77; push_exp(8'h01); push_exp(8'h77);
        cyc(); idle();
        check("rw_same_cycle_old", 32'(data_out_a));
        check("rc_write_beats_clear", reg_of(data_q_a, 2));

        // Lock
        lock = 1'b1; we = 1'b1; addr = 3'd0; data_in = 8'h33; push_exp(8'h11); push_exp(1);
        cyc(); idle();
        check("lock_reg0_unchanged", reg_of(data_q_a, 0));
        check("lock_wr_err", 32'(wr_err_a));
        push_exp(0);
        cyc();
        check("lock_wr_err_one_cycle", 32'(wr_err_a));
        lock = 1'b0; we = 1'b1; addr = 3'd0; data_in = 8'h33; push_exp(8'h33); push_exp(0);
        cyc(); idle();
        check("unlock_write", reg_of(data_q_a, 0));
        check("unlock_no_wr_err", 32'(wr_err_a));

        // Shadow and commit
        we = 1'b1; addr = 3'd3; data_in = 8'hA5; push_exp(8'h07); push_exp(4'b1000);
        cyc(); idle();
        check("shadow_live_unchanged", reg_of(data_q_a, 3));
        check("shadow_pending", 32'(pending_a));
        commit = 1'b1; push_exp(8'hA5); push_exp(0);
        cyc(); idle();
        check("commit_live", reg_of(data_q_a, 3));
        check("commit_pending_clear", 32'(pending_a));
        we = 1'b1; commit = 1'b1; addr = 3'd3; data_in = 8'h3C; push_exp(8'h3C); push_exp(0);
        cyc(); idle();
        check("commit_same_cycle", reg_of(data_q_a, 3));
        check("commit_same_pending", 32'(pending_a));

        // RO register and out-of-range address
        we = 1'b1; addr = 3'd3; data_in = 8'h55; push_exp(1); push_exp(8'h07);
        cyc(); idle();
        check("ro_wr_err", 32'(wr_err_b));
        check("ro_unchanged", reg_of(data_q_b, 3));
        we = 1'b1; addr = 3'd5; data_in = 8'hFF; push_exp(1); push_exp(32'h3C77_8033);
        cyc(); idle();
        check("oor_wr_err", 32'(wr_err_a));
        check("oor_no_change", data_q_a);
        re = 1'b1; addr = 3'd5; push_exp(0);
        cyc(); idle();
        check("oor_read_zero", 32'(data_out_a));

        // Asynchronous reset mid-write, then first access after release
        we = 1'b1; addr = 3'd0; data_in = 8'h99;
        rst = 1'b1; push_exp(RV); push_exp(0);
        #2;
        check("async_rst_data_q", data_q_a);
        check("async_rst_pending", 32'(pending_a));
        cyc();
        rst = 1'b0; push_exp(8'h99);
        cyc(); idle();
        check("first_access_after_rst", reg_of(data_q_a, 0));
        re = 1'b1; addr = 3'd0; push_exp(8'h99);
        cyc(); idle();
        check("read_after_rst", 32'(data_out_a));
        we = 1'b1; addr = 3'd3; data_in = 8'h44; push_exp(4'b1000);
        cyc(); idle();
        check("pending_before_sync", 32'(pending_a));

        // Synchronous reset discards same-cycle accesses
        rst_sync = 1'b1; we = 1'b1; re = 1'b1; commit = 1'b1; addr = 3'd3;
        data_in = 8'h3C; hw_set = '1;
        push_exp(RV); push_exp(0); push_exp(0); push_exp(0); push_exp(0);
        cyc(); idle();
        check("sync_rst_data_q", data_q_a);
        check("sync_rst_pending", 32'(pending_a));
        check("sync_rst_data_out", 32'(data_out_a));
        check("sync_rst_wr_err_a", 32'(wr_err_a));
        check("sync_rst_wr_err_b", 32'(wr_err_b));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/can_register_bank.md
CAN_REGISTER_BANK -- requirements
Module: can_register_bank

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits.
REQ-002 Parameter DEPTH, default 4, number of registers (range 2..16).
REQ-003 Parameter ADDR_W, default 2, address width; 2**ADDR_W >= DEPTH.
REQ-004 Parameter RESET_VALUE, default 0, DEPTH*WIDTH flattened; register i occupies bits [i*WIDTH +: WIDTH].
REQ-005 Parameter MODE, default 0, 2*DEPTH bits, 2 bits per register: 0=RW, 1=RO (HW-set only), 2=W1C, 3=RC (clear on read).
REQ-006 Parameter LOCK_MASK, default 0, DEPTH bits; a set bit makes that register write-protected while lock=1.
REQ-007 Parameter SHADOW_MASK, default 0, DEPTH bits; a set bit makes writes to that register land in a shadow copy until commit.
REQ-008 clk  in  1  single clock; all state updates on its rising edge.
REQ-009 rst  in  1  asynchronous, active-high reset.
REQ-010 rst_sync  in  1  synchronous reset; same effect as rst at the next clk edge.
REQ-011 addr  in  ADDR_W  register index for we/re.
REQ-012 data_in  in  WIDTH  write data.
REQ-013 we  in  1  write strobe, one access per cycle.
REQ-014 re  in  1  read strobe.
REQ-015 lock  in  1  write protect for LOCK_MASK registers (CAN reset-mode gating).
REQ-016 commit  in  1  single-cycle pulse; transfers all shadow registers to live.
REQ-017 hw_set  in  DEPTH*WIDTH  per-bit hardware set requests, layout as RESET_VALUE.
REQ-018 data_out  out  WIDTH  registered read data.
REQ-019 data_q  out  DEPTH*WIDTH  live contents of all registers.
REQ-020 pending  out  DEPTH  per register: shadow written, not yet committed.
REQ-021 wr_err  out  1  one-cycle pulse on a rejected write.

Function
REQ-022 A write is accepted when we=1, addr<DEPTH, MODE!=RO, and not (lock=1 and LOCK_MASK[addr]=1); otherwise it is rejected, no state changes, and wr_err=1 on the next cycle.
REQ-023 Accepted RW/RC write: live register <= data_in at the next edge.
REQ-024 Accepted W1C write: live register <= live & ~data_in.
REQ-025 Accepted write to a SHADOW_MASK register: shadow <= data_in, live unchanged, pending[addr] <= 1; W1C/RC registers with SHADOW_MASK set are illegal configurations, flagged by an elaboration-time check.
REQ-026 commit=1: every shadowed register live <= shadow and pending <= 0; if a shadow write occurs in the same cycle, data_in is committed directly (live = shadow = data_in, pending stays 0).
REQ-027 hw_set bits OR into live on every cycle for every mode; set wins over a same-cycle W1C clear, RC clear or commit on the same bit.
REQ-028 Read: re=1 and addr<DEPTH -> data_out <= live[addr] (pre-update value) at the next edge, one-cycle latency; re=1 with addr>=DEPTH -> data_out <= 0; re=0 -> data_out holds.
REQ-029 RC read: live[addr] <= 0 at the same edge, except bits that hw_set asserts that cycle.
REQ-030 Same-cycle we and re to the same address: data_out returns the old value, and the write takes effect (an RC register takes the write value, not a clear).
REQ-031 data_q is combinational from the live registers, with no extra latency.
REQ-032 Per-bit priority: rst > rst_sync > hw_set > commit / write / RC clear.

Reset
REQ-033 On rst (immediately) or rst_sync (at the next edge): live and shadow <= RESET_VALUE, pending <= 0, data_out <= 0, wr_err <= 0.
REQ-034 rst_sync also discards any same-cycle we, re, commit and hw_set.
REQ-035 rst deassertion mid-operation: the first accepted access is in the first cycle with rst=0.

Verification
REQ-036 WIDTH=8, DEPTH=4, MODE reg1=W1C: hw_set reg1=0x81 for 1 cycle, then write 0x01 to reg1 -> data_q reg1 = 0x81, then 0x80; write 0x80 with hw_set 0x80 in the same cycle -> reg1 stays 0x80.
REQ-037 reg2=RC holding 0x5A: re addr2 -> data_out=0x5A next cycle, reg2=0x00; repeat with hw_set bit0 in the same cycle -> reg2=0x01.
REQ-038 LOCK_MASK reg0=1, lock=1, write 0x33 to addr0 -> reg0 unchanged and wr_err pulses for 1 cycle; lock=0, same write -> reg0=0x33, no wr_err.
REQ-039 SHADOW_MASK reg3=1: write 0xA5 -> data_q reg3 unchanged and pending[3]=1; commit -> reg3=0xA5 and pending[3]=0; write 0x3C with commit in the same cycle -> reg3=0x3C and pending[3]=0.
REQ-040 Write addr3=RO or addr>=DEPTH (ADDR_W=3) -> wr_err pulse, no change; read addr 5 -> data_out=0x00.
REQ-041 rst pulse mid-write and rst_sync with we+commit -> all registers equal RESET_VALUE, pending=0, data_out=0.
